// File: rtl/ddr_bank_cmd_sequencer_pkg.sv
// Shared types and constants for the DDR bank command sequencer.
//   ddr_cmd_t          scheduled BL16 command from the channel/rank scheduler
//   ddr_phy_op_e       primitive opcode toward the PHY (NOP/ACT/PRE/RD/WR)
//   ddr_bank_state_t   per-bank open flag and open row
//   ddr_bank_status_t  bank state plus "timing gate expired" flags
//   cnt_width()        counter width able to hold T-1 for a timing value T
package ddr_bank_cmd_sequencer_pkg;

  localparam int unsigned DDR_ADDR_W       = 32;
  localparam int unsigned DDR_CMD_RANK_W   = 2;
  localparam int unsigned DDR_SLOT_W       = 4;
  localparam int unsigned DDR_LEN_W        = 4;
  localparam int unsigned DDR_MAX_ROW_BITS = 24;

  // Default DRAM timing, in controller clock cycles.
  localparam int unsigned DEF_T_RCD = 4;
  localparam int unsigned DEF_T_RP  = 4;
  localparam int unsigned DEF_T_RAS = 10;
  localparam int unsigned DEF_T_WR  = 6;
  localparam int unsigned DEF_T_CCD = 2;

  typedef enum logic [2:0] {
    PhyNop = 3'd0,
    PhyAct = 3'd1,
    PhyPre = 3'd2,
    PhyRd  = 3'd3,
    PhyWr  = 3'd4
  } ddr_phy_op_e;

  typedef struct packed {
    logic                      is_write;
    logic [DDR_ADDR_W-1:0]     addr;
    logic [DDR_CMD_RANK_W-1:0] rank;
    logic                      channel;
    logic [DDR_SLOT_W-1:0]     slot;
    logic [DDR_LEN_W-1:0]      len;
  } ddr_cmd_t;

  typedef struct packed {
    logic                        open;
    logic [DDR_MAX_ROW_BITS-1:0] row;
  } ddr_bank_state_t;

  typedef struct packed {
    ddr_bank_state_t st;
    logic            rcd_zero;
    logic            ras_zero;
    logic            rp_zero;
    logic            wr_zero;
  } ddr_bank_status_t;

  // Counters are loaded with T-1, so clog2(T) bits are enough.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/ddr_bank_cmd_sequencer_if.sv
// Scheduler-side command handshake, hazard feedback and PHY primitive bus.
//   slave  : the sequencer (accepts cmd, drives busy flags and phy_*)
//   master : the environment (scheduler drives cmd, PHY drives phy_ready)
interface ddr_bank_cmd_sequencer_if
  import ddr_bank_cmd_sequencer_pkg::*;
#(
  parameter int unsigned NUM_RANKS = 2,
  parameter int unsigned NUM_BANKS = 32,
  parameter int unsigned COL_BITS  = 10,
  parameter int unsigned ROW_BITS  = 16
) ();

  localparam int unsigned RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int unsigned BANK_W = $clog2(NUM_BANKS);

  logic              cmd_valid;
  logic              cmd_ready;
  ddr_cmd_t          cmd;
  logic              bank_busy;
  logic              rank_busy;
  logic              phy_valid;
  logic              phy_ready;
  ddr_phy_op_e       phy_op;
  logic [RANK_W-1:0] phy_rank;
  logic [BANK_W-1:0] phy_bank;
  logic [ROW_BITS-1:0] phy_row;
  logic [COL_BITS-1:0] phy_col;

  modport slave (
    input  cmd_valid, cmd, phy_ready,
    output cmd_ready, bank_busy, rank_busy,
    output phy_valid, phy_op, phy_rank, phy_bank, phy_row, phy_col
  );

  modport master (
    output cmd_valid, cmd, phy_ready,
    input  cmd_ready, bank_busy, rank_busy,
    input  phy_valid, phy_op, phy_rank, phy_bank, phy_row, phy_col
  );

endinterface

// File: rtl/ddr_bank_cmd_sequencer_bank_timer.sv
// One DRAM bank: open flag, open row and the rcd/ras/rp/wr timing counters.
//   clk, rst_n     clock, asynchronous active-low reset
//   act_load       ACT handshaked: open the bank at act_row, load rcd and ras
//   act_row        row being activated
//   pre_load       PRE handshaked: close the bank, load rp
//   wr_load        WR handshaked: load wr
//   status         open state plus per-counter "expired" flags
// Each counter loads T-1 and counts down to 0, so a dependent primitive is
// legal T cycles after the loading handshake.
module ddr_bank_cmd_sequencer_bank_timer
  import ddr_bank_cmd_sequencer_pkg::*;
#(
  parameter int unsigned ROW_BITS = 16,
  parameter int unsigned T_RCD    = DEF_T_RCD,
  parameter int unsigned T_RAS    = DEF_T_RAS,
  parameter int unsigned T_RP     = DEF_T_RP,
  parameter int unsigned T_WR     = DEF_T_WR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                act_load,
  input  logic [ROW_BITS-1:0] act_row,
  input  logic                pre_load,
  input  logic                wr_load,
  output ddr_bank_status_t    status
);

  localparam int unsigned RCD_W = cnt_width(T_RCD);
  localparam int unsigned RAS_W = cnt_width(T_RAS);
  localparam int unsigned RP_W  = cnt_width(T_RP);
  localparam int unsigned WR_W  = cnt_width(T_WR);

  logic                open_q;
  logic [ROW_BITS-1:0] row_q;
  logic [RCD_W-1:0]    rcd_q;
  logic [RAS_W-1:0]    ras_q;
  logic [RP_W-1:0]     rp_q;
  logic [WR_W-1:0]     wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      row_q  <= '0;
    end else if (act_load) begin
      open_q <= 1'b1;
      row_q  <= act_row;
    end else if (pre_load) begin
      open_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcd_q <= '0;
      ras_q <= '0;
    end else if (act_load) begin
      rcd_q <= RCD_W'(T_RCD - 1);
      ras_q <= RAS_W'(T_RAS - 1);
    end else begin
      if (rcd_q != '0) rcd_q <= rcd_q - RCD_W'(1);
      if (ras_q != '0) ras_q <= ras_q - RAS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_q <= '0;
    end else if (pre_load) begin
      rp_q <= RP_W'(T_RP - 1);
    end else if (rp_q != '0) begin
      rp_q <= rp_q - RP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
    end else if (wr_load) begin
      wr_q <= WR_W'(T_WR - 1);
    end else if (wr_q != '0) begin
      wr_q <= wr_q - WR_W'(1);
    end
  end

  always_comb begin
    status.st.open = open_q;
    status.st.row  = DDR_MAX_ROW_BITS'(row_q);
    status.rcd_zero = (rcd_q == '0);
    status.ras_zero = (ras_q == '0);
    status.rp_zero  = (rp_q == '0);
    status.wr_zero  = (wr_q == '0);
  end

endmodule

// File: rtl/ddr_bank_cmd_sequencer.sv
// Expands one scheduled BL16 command at a time into PRE/ACT/RD/WR primitives
// under an open-page policy, tracking per-bank row state and timing.
//   clk, rst_n         clock, asynchronous active-low reset
//   bus.cmd_valid/ready/cmd   command from the scheduler (one in flight)
//   bus.bank_busy      a command is in flight
//   bus.rank_busy      some rank's tCCD window is still open
//   bus.phy_valid/ready/op/rank/bank/row/col   primitive toward the PHY
module ddr_bank_cmd_sequencer
  import ddr_bank_cmd_sequencer_pkg::*;
#(
  parameter int unsigned NUM_RANKS = 2,
  parameter int unsigned NUM_BANKS = 32,
  parameter int unsigned COL_BITS  = 10,
  parameter int unsigned ROW_BITS  = 16,
  parameter int unsigned T_RCD     = DEF_T_RCD,
  parameter int unsigned T_RP      = DEF_T_RP,
  parameter int unsigned T_RAS     = DEF_T_RAS,
  parameter int unsigned T_WR      = DEF_T_WR,
  parameter int unsigned T_CCD     = DEF_T_CCD
) (
  input logic                     clk,
  input logic                     rst_n,
  ddr_bank_cmd_sequencer_if.slave bus
);

  localparam int unsigned RANK_W      = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int unsigned BANK_W      = $clog2(NUM_BANKS);
  localparam int unsigned IDX_W       = RANK_W + BANK_W;
  localparam int unsigned NUM_ENTRIES = NUM_RANKS * NUM_BANKS;
  localparam int unsigned CCD_W       = cnt_width(T_CCD);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLookup = 3'd1;
  localparam logic [2:0] StPre    = 3'd2;
  localparam logic [2:0] StAct    = 3'd3;
  localparam logic [2:0] StCol    = 3'd4;

  if (COL_BITS + BANK_W + ROW_BITS > DDR_ADDR_W) begin : gen_addr_too_narrow
    $error("command address narrower than COL_BITS + bank bits + ROW_BITS");
  end
  if (ROW_BITS > DDR_MAX_ROW_BITS) begin : gen_row_too_wide
    $error("ROW_BITS exceeds DDR_MAX_ROW_BITS");
  end
  if (RANK_W > DDR_CMD_RANK_W) begin : gen_rank_too_wide
    $error("NUM_RANKS exceeds the command rank field");
  end
  if (NUM_BANKS < 2 || (1 << BANK_W) != NUM_BANKS) begin : gen_bad_banks
    $error("NUM_BANKS must be a power of two, at least 2");
  end
  if (T_RCD < 1 || T_RP < 1 || T_RAS < 1 || T_WR < 1 || T_CCD < 1) begin : gen_bad_timing
    $error("timing parameters must be at least 1");
  end

  logic [2:0]          state_q, state_d;
  logic [RANK_W-1:0]   rank_q;
  logic [BANK_W-1:0]   bank_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic                is_write_q;

  logic [IDX_W-1:0]    sel_idx;
  ddr_bank_status_t    bank_status [NUM_ENTRIES];
  ddr_bank_status_t    sel_status;
  logic                row_hit;

  logic [CCD_W-1:0]    ccd_q [NUM_RANKS];
  logic                ccd_sel_zero;
  logic                rank_busy;

  logic                cmd_ready;
  logic                phy_valid;
  ddr_phy_op_e         phy_op;
  logic [RANK_W-1:0]   phy_rank;
  logic [BANK_W-1:0]   phy_bank;
  logic [ROW_BITS-1:0] phy_row;
  logic [COL_BITS-1:0] phy_col;

  logic                phy_fire;
  logic                act_fire;
  logic                pre_fire;
  logic                col_fire;

  // channel, slot, len and any spare address/rank bits are not used here.
  logic unused_cmd;
  assign unused_cmd = ^bus.cmd;

  // Hold register: captured on acceptance, stable for the whole expansion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rank_q     <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      is_write_q <= 1'b0;
    end else if (state_q == StIdle && bus.cmd_valid) begin
      rank_q     <= bus.cmd.rank[RANK_W-1:0];
      bank_q     <= bus.cmd.addr[COL_BITS +: BANK_W];
      row_q      <= bus.cmd.addr[COL_BITS + BANK_W +: ROW_BITS];
      col_q      <= bus.cmd.addr[COL_BITS-1:0];
      is_write_q <= bus.cmd.is_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign sel_idx    = {rank_q, bank_q};
  assign sel_status = bank_status[sel_idx];
  assign row_hit    = (sel_status.st.row == DDR_MAX_ROW_BITS'(row_q));

  assign phy_fire = phy_valid & bus.phy_ready;
  assign act_fire = phy_fire & (state_q == StAct);
  assign pre_fire = phy_fire & (state_q == StPre);
  assign col_fire = phy_fire & (state_q == StCol);

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : gen_bank
    logic sel;
    assign sel = (sel_idx == IDX_W'(i));

    ddr_bank_cmd_sequencer_bank_timer #(
      .ROW_BITS (ROW_BITS),
      .T_RCD    (T_RCD),
      .T_RAS    (T_RAS),
      .T_RP     (T_RP),
      .T_WR     (T_WR)
    ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .act_load (act_fire & sel),
      .act_row  (row_q),
      .pre_load (pre_fire & sel),
      .wr_load  (col_fire & sel & is_write_q),
      .status   (bank_status[i])
    );
  end

  // Per-rank column-to-column spacing; loaded by every RD/WR on that rank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RANKS; r++) ccd_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_RANKS; r++) begin
        if (col_fire && rank_q == RANK_W'(r)) begin
          ccd_q[r] <= CCD_W'(T_CCD - 1);
        end else if (ccd_q[r] != '0) begin
          ccd_q[r] <= ccd_q[r] - CCD_W'(1);
        end
      end
    end
  end

  assign ccd_sel_zero = (ccd_q[rank_q] == '0);

  always_comb begin
    rank_busy = 1'b0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (ccd_q[r] != '0) rank_busy = 1'b1;
    end
  end

  // Gate conditions only depend on counters that are already zero and have
  // no load pending, so an offered primitive stays offered until taken.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    phy_valid = 1'b0;
    phy_op    = PhyNop;
    phy_rank  = '0;
    phy_bank  = '0;
    phy_row   = '0;
    phy_col   = '0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = StLookup;
      end
      StLookup: begin
        if (!sel_status.st.open) begin
          state_d = StAct;
        end else if (row_hit) begin
          state_d = StCol;
        end else begin
          state_d = StPre;
        end
      end
      StPre: begin
        phy_valid = sel_status.ras_zero & sel_status.wr_zero;
        if (phy_valid) begin
          phy_op   = PhyPre;
          phy_rank = rank_q;
          phy_bank = bank_q;
          if (bus.phy_ready) state_d = StAct;
        end
      end
      StAct: begin
        phy_valid = sel_status.rp_zero;
        if (phy_valid) begin
          phy_op   = PhyAct;
          phy_rank = rank_q;
          phy_bank = bank_q;
          phy_row  = row_q;
          if (bus.phy_ready) state_d = StCol;
        end
      end
      StCol: begin
        phy_valid = sel_status.rcd_zero & ccd_sel_zero;
        if (phy_valid) begin
          phy_op   = is_write_q ? PhyWr : PhyRd;
          phy_rank = rank_q;
          phy_bank = bank_q;
          phy_col  = col_q;
          if (bus.phy_ready) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.bank_busy = (state_q != StIdle);
  assign bus.rank_busy = rank_busy;
  assign bus.phy_valid = phy_valid;
  assign bus.phy_op    = phy_op;
  assign bus.phy_rank  = phy_rank;
  assign bus.phy_bank  = phy_bank;
  assign bus.phy_row   = phy_row;
  assign bus.phy_col   = phy_col;

endmodule

// File: tb/tb_ddr_bank_cmd_sequencer.sv
// Directed bench: stimulus pushes expected PHY primitives (with cycle offsets
// relative to each command's acceptance) into a queue; a monitor pops and
// compares on every PHY handshake and checks hold/idle rules every cycle.
module tb_ddr_bank_cmd_sequencer;
  import ddr_bank_cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_bank_cmd_sequencer_if #(
    .NUM_RANKS (2),
    .NUM_BANKS (32),
    .COL_BITS  (10),
    .ROW_BITS  (16)
  ) bus ();

  ddr_bank_cmd_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    ddr_phy_op_e op;
    logic        rank;
    logic [4:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    int          id;
    int          off;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc [32];
  int   next_id = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_prim(input ddr_phy_op_e op, input logic rank, input logic [4:0] bank,
                             input logic [15:0] row, input logic [9:0] col, input int off);
    exp_t e;
    e.op = op; e.rank = rank; e.bank = bank; e.row = row; e.col = col;
    e.id = next_id; e.off = off;
    exp_q.push_back(e);
  endtask

  // Presents a command and returns the cycle in which it was accepted.
  task automatic send(input logic w, input logic rank, input logic [4:0] bank,
                      input logic [15:0] row, input logic [9:0] col, output int acc);
    ddr_cmd_t c;
    c = '0;
    c.is_write    = w;
    c.rank        = {1'b0, rank};
    c.addr[9:0]   = col;
    c.addr[14:10] = bank;
    c.addr[30:15] = row;
    c.channel     = 1'b1;
    c.slot        = 4'hA;
    c.len         = 4'h3;
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for 100 cycles");
      acc = cyc;
    end
    acc_cyc[next_id] = acc;
    next_id++;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd = '1;
  endtask

  // Monitor
  logic        prev_stall = 1'b0;
  ddr_phy_op_e prev_op;
  logic        prev_rank;
  logic [4:0]  prev_bank;
  logic [15:0] prev_row;
  logic [9:0]  prev_col;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("held_valid", bus.phy_valid, 1);
        chk("held_fields", {bus.phy_op, bus.phy_rank, bus.phy_bank, bus.phy_row, bus.phy_col},
            {prev_op, prev_rank, prev_bank, prev_row, prev_col});
      end
      if (bus.phy_valid) begin
        if (bus.phy_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_prim: got op %0d bank %0d, expected no primitive",
                     bus.phy_op, bus.phy_bank);
          end else begin
            m_e = exp_q.pop_front();
            chk("prim_op", bus.phy_op, m_e.op);
            chk("prim_rank", bus.phy_rank, m_e.rank);
            chk("prim_bank", bus.phy_bank, m_e.bank);
            chk("prim_row", bus.phy_row, m_e.row);
            chk("prim_col", bus.phy_col, m_e.col);
            chk("prim_cycle", cyc - acc_cyc[m_e.id], m_e.off);
          end
        end
      end else begin
        chk("idle_fields", {bus.phy_op, bus.phy_rank, bus.phy_bank, bus.phy_row, bus.phy_col},
            0);
      end
      prev_stall <= bus.phy_valid & ~bus.phy_ready;
      prev_op    <= bus.phy_op;
      prev_rank  <= bus.phy_rank;
      prev_bank  <= bus.phy_bank;
      prev_row   <= bus.phy_row;
      prev_col   <= bus.phy_col;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_bank_busy"}, bus.bank_busy, 0);
    chk({tag, "_rank_busy"}, bus.rank_busy, 0);
    chk({tag, "_phy_valid"}, bus.phy_valid, 0);
    chk({tag, "_phy_fields"}, {bus.phy_op, bus.phy_rank, bus.phy_bank, bus.phy_row, bus.phy_col},
        0);
  endtask

  int t0, a1, a2, a3, b0, b1, b2, c0, c1, c2;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.phy_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Closed-bank write: ACT at +2, WR at +2+T_RCD.
    expect_prim(PhyAct, 1'b0, 5'd3, 16'h0012, 10'h000, 2);
    expect_prim(PhyWr,  1'b0, 5'd3, 16'h0000, 10'h005, 6);
    send(1'b1, 1'b0, 5'd3, 16'h0012, 10'h005, t0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("busy_in_flight", bus.bank_busy, 1);
      chk("ready_low_in_flight", bus.cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    chk("ready_after_col", bus.cmd_ready, 1);
    chk("idle_after_col", bus.bank_busy, 0);
    chk("rank_busy_after_wr", bus.rank_busy, 1);

    // Row hit read, accepted at 7: RD at 9.
    expect_prim(PhyRd, 1'b0, 5'd3, 16'h0000, 10'h007, 2);
    send(1'b0, 1'b0, 5'd3, 16'h0012, 10'h007, a1);
    chk("hit_accept_cycle", a1 - t0, 7);
    chk("rank_busy_expired", bus.rank_busy, 0);

    // Row conflict at 10: PRE 12 (tRAS/tWR expire), ACT 16, WR 20.
    expect_prim(PhyPre, 1'b0, 5'd3, 16'h0000, 10'h000, 2);
    expect_prim(PhyAct, 1'b0, 5'd3, 16'h0034, 10'h000, 6);
    expect_prim(PhyWr,  1'b0, 5'd3, 16'h0000, 10'h3FF, 10);
    send(1'b1, 1'b0, 5'd3, 16'h0034, 10'h3FF, a2);
    chk("conflict_accept_cycle", a2 - t0, 10);

    // PHY stall of 5 cycles on ACT; RD exactly T_RCD after the real ACT.
    expect_prim(PhyAct, 1'b1, 5'd31, 16'hFFFF, 10'h000, 7);
    expect_prim(PhyRd,  1'b1, 5'd31, 16'h0000, 10'h000, 11);
    send(1'b0, 1'b1, 5'd31, 16'hFFFF, 10'h000, a3);
    bus.phy_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.phy_ready = 1'b1;

    // Back-to-back hits: rank 0, rank 1, rank 1 again.
    expect_prim(PhyRd, 1'b0, 5'd3, 16'h0000, 10'h001, 2);
    send(1'b0, 1'b0, 5'd3, 16'h0034, 10'h001, b0);
    expect_prim(PhyRd, 1'b1, 5'd31, 16'h0000, 10'h002, 2);
    send(1'b0, 1'b1, 5'd31, 16'hFFFF, 10'h002, b1);
    chk("rank1_accept_gap", b1 - b0, 3);
    expect_prim(PhyWr, 1'b1, 5'd31, 16'h0000, 10'h003, 2);
    send(1'b1, 1'b1, 5'd31, 16'hFFFF, 10'h003, b2);
    chk("same_rank_accept_gap", b2 - b1, 3);

    // Reset while ACT is stalled; nothing may be emitted afterwards.
    send(1'b0, 1'b0, 5'd7, 16'h0055, 10'h009, c0);
    bus.phy_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stalled_act_valid", bus.phy_valid, 1);
    chk("stalled_act_op", bus.phy_op, PhyAct);
    chk("stalled_act_row", bus.phy_row, 16'h0055);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.phy_ready = 1'b1;
    #1;
    chk_reset_outputs("post_reset");
    repeat (4) @(posedge clk);
    #1;

    // Both banks must be closed again: each access starts with ACT.
    expect_prim(PhyAct, 1'b0, 5'd7, 16'h0055, 10'h000, 2);
    expect_prim(PhyRd,  1'b0, 5'd7, 16'h0000, 10'h009, 6);
    send(1'b0, 1'b0, 5'd7, 16'h0055, 10'h009, c1);
    expect_prim(PhyAct, 1'b0, 5'd3, 16'h0034, 10'h000, 2);
    expect_prim(PhyWr,  1'b0, 5'd3, 16'h0000, 10'h008, 6);
    send(1'b1, 1'b0, 5'd3, 16'h0034, 10'h008, c2);

    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
